// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word-addressed memory.
// Sub-word stores use read-modify-write; bad requests answer with rsp_err.
module load_store_unit #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    typedef enum logic [2:0] {
        IDLE, LOAD, STORE_RD, STORE_WR, ERR
    } state_t;

    localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        req_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Reject illegal encodings, misalignment and out-of-range word indices
    always_comb begin
        req_err = 1'b0;
        unique case (req_funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = req_addr[0];
            3'b010:  req_err = |req_addr[1:0];
            3'b100:  req_err = req_we;
            3'b101:  req_err = req_we | req_addr[0];
            default: req_err = 1'b1;
        endcase
        if (req_addr[31:2] >= DEPTH_W) req_err = 1'b1;
    end

    // Extract the addressed lane of the read word and extend it
    always_comb begin
        ld_byte = mem_RD[7:0];
        unique case (addr_q[1:0])
            2'd0: ld_byte = mem_RD[7:0];
            2'd1: ld_byte = mem_RD[15:8];
            2'd2: ld_byte = mem_RD[23:16];
            2'd3: ld_byte = mem_RD[31:24];
        endcase
        ld_half = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
        unique case (funct3_q)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'h0, ld_byte};
            3'b101:  load_data = {16'h0, ld_half};
            default: load_data = mem_RD;
        endcase
    end

    // Replace only the addressed lane of the captured word
    always_comb begin
        merged = merge_q;
        if (!funct3_q[0]) begin
            unique case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // Next-state, memory port and response computation
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        merge_d     = merge_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
        req_ready   = 1'b0;
        mem_A       = 32'h0;
        mem_WD      = 32'h0;
        mem_WE      = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_err)                  state_d = ERR;
                    else if (!req_we)             state_d = LOAD;
                    else if (req_funct3 == 3'b010) state_d = STORE_WR;
                    else                          state_d = STORE_RD;
                end
            end
            LOAD: begin
                mem_A       = {2'b00, addr_q[31:2]};
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_data;
                state_d     = IDLE;
            end
            STORE_RD: begin
                mem_A   = {2'b00, addr_q[31:2]};
                merge_d = mem_RD;
                state_d = STORE_WR;
            end
            STORE_WR: begin
                mem_A       = {2'b00, addr_q[31:2]};
                mem_WE      = we_q;
                mem_WD      = (funct3_q == 3'b010) ? wdata_q : merged;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            merge_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            merge_q     <= merge_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: request-level model with a response queue,
// an attached 64-word memory, and directed vectors with literal checks.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    load_store_unit #(.DEPTH_WORDS(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          acc;
        int          due;
        logic [31:0] rdata;
        logic        err;
        logic        wr;
        int          widx;
        logic [31:0] wdata;
    } exp_t;

    exp_t        q[$];
    logic [31:0] tb_mem[64];
    logic [31:0] ref_mem[64];
    logic        load_mem;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          rsp_count = 0;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    assign mem_RD = (mem_A < 64) ? tb_mem[mem_A[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= ref_mem[i];
        end else if (mem_WE && mem_A < 64) begin
            tb_mem[mem_A[5:0]] <= mem_WD;
        end
    end

    // Request-level model: decide the outcome of each accepted request
    always @(posedge clk) begin
        int          k;
        int          size;
        int          sh;
        logic [29:0] widx;
        logic        legal;
        logic [31:0] word;
        logic [31:0] v;
        logic [31:0] mask;
        exp_t        e;
        k = cyc;
        cyc = cyc + 1;
        if (reset) begin
            q.delete();
        end else if (req_valid && req_ready) begin
            size  = 1 << req_funct3[1:0];
            sh    = 8 * int'(req_addr[1:0]);
            widx  = req_addr[31:2];
            legal = (req_funct3 == 3'd0 || req_funct3 == 3'd1 ||
                     req_funct3 == 3'd2 ||
                     ((req_funct3 == 3'd4 || req_funct3 == 3'd5) && !req_we));
            legal = legal && ((req_addr % size) == 0) && (widx < 64);
            e.acc   = k;
            e.rdata = 32'h0;
            e.err   = 1'b0;
            e.wr    = 1'b0;
            e.widx  = int'(widx);
            e.wdata = 32'h0;
            if (!legal) begin
                e.err = 1'b1;
                e.due = k + 2;
            end else begin
                word = ref_mem[widx[5:0]];
                if (!req_we) begin
                    v = word >> sh;
                    if (size == 1) begin
                        v = v & 32'hFF;
                        if (req_funct3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
                    end else if (size == 2) begin
                        v = v & 32'hFFFF;
                        if (req_funct3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
                    end
                    e.rdata = v;
                    e.due   = k + 2;
                end else begin
                    if (size == 4) mask = 32'hFFFFFFFF;
                    else if (size == 2) mask = 32'hFFFF << sh;
                    else mask = 32'hFF << sh;
                    e.wr    = 1'b1;
                    e.wdata = (word & ~mask) | ((req_wdata << sh) & mask);
                    e.due   = (size == 4) ? k + 2 : k + 3;
                end
            end
            q.push_back(e);
        end
    end

    // Compare DUT memory writes and responses against the model each cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_WE) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL mem_write: unexpected write A=%0d WD=%h", mem_A, mem_WD);
                end else if (!q[0].wr || q[0].due != cyc + 1 ||
                             mem_A != q[0].widx || mem_WD != q[0].wdata) begin
                    bad++;
                    $display("FAIL mem_write: got A=%0d WD=%h want A=%0d WD=%h wr=%0d",
                             mem_A, mem_WD, q[0].widx, q[0].wdata, q[0].wr);
                end
            end
            if (rsp_valid) begin
                total++;
                rsp_count++;
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rsp: unexpected response rdata=%h err=%0d", rsp_rdata, rsp_err);
                end else begin
                    last_lat = cyc - q[0].acc - 1;
                    if (q[0].due != cyc || rsp_rdata !== q[0].rdata || rsp_err !== q[0].err) begin
                        bad++;
                        $display("FAIL rsp: got rdata=%h err=%0d cyc=%0d want rdata=%h err=%0d cyc=%0d",
                                 rsp_rdata, rsp_err, cyc, q[0].rdata, q[0].err, q[0].due);
                    end
                    if (q[0].wr) ref_mem[q[0].widx[5:0]] = q[0].wdata;
                    void'(q.pop_front());
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                total++;
                bad++;
                $display("FAIL rsp: missing response got none want rdata=%h err=%0d",
                         q[0].rdata, q[0].err);
                void'(q.pop_front());
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Present a request at a falling edge and hold it until accepted
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit keep, output logic saw_rsp);
        int n;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        saw_rsp    = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got req_ready=0 want 1");
        end else begin
            saw_rsp = rsp_valid;
            @(posedge clk);
            @(negedge clk);
        end
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
    } err_vec_t;

    initial begin
        logic     s;
        int       rc;
        err_vec_t ev[4];
        ev[0] = '{1'b0, 3'b010, 32'h02};
        ev[1] = '{1'b1, 3'b001, 32'h03};
        ev[2] = '{1'b1, 3'b010, 32'h100};
        ev[3] = '{1'b0, 3'b011, 32'h00};
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA5000000 | i;
        ref_mem[1] = 32'h11223344;
        reset = 1'b1;
        load_mem = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'h0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        load_mem = 1'b0;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_WE}, 32'h0);
        chk("rst_mem_a", mem_A, 32'h0);
        chk("rst_mem_wd", mem_WD, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, s);
        drain();
        chk("sw_lat", last_lat, 32'd1);
        chk("sw_err", {31'h0, last_err}, 32'h0);
        chk("sw_mem", tb_mem[4], 32'hDEADBEEF);
        send(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, s);
        drain();
        chk("lw_data", last_rdata, 32'hDEADBEEF);
        chk("lw_lat", last_lat, 32'd1);

        send(1'b1, 3'b000, 32'h05, 32'h000000AB, 1'b0, s);
        drain();
        chk("sb_lat", last_lat, 32'd2);
        chk("sb_mem", tb_mem[1], 32'h1122AB44);
        send(1'b0, 3'b000, 32'h05, 32'h0, 1'b0, s);
        drain();
        chk("lb_data", last_rdata, 32'hFFFFFFAB);
        send(1'b0, 3'b100, 32'h05, 32'h0, 1'b0, s);
        drain();
        chk("lbu_data", last_rdata, 32'h000000AB);

        send(1'b1, 3'b001, 32'h06, 32'h00008001, 1'b0, s);
        drain();
        chk("sh_mem", tb_mem[1], 32'h8001AB44);
        send(1'b0, 3'b001, 32'h06, 32'h0, 1'b0, s);
        drain();
        chk("lh_data", last_rdata, 32'hFFFF8001);
        send(1'b0, 3'b101, 32'h06, 32'h0, 1'b0, s);
        drain();
        chk("lhu_data", last_rdata, 32'h00008001);

        for (int i = 0; i < 4; i++) begin
            send(ev[i].we, ev[i].f3, ev[i].addr, 32'hFFFFFFFF, 1'b0, s);
            drain();
            chk($sformatf("err%0d_flag", i), {31'h0, last_err}, 32'h1);
            chk($sformatf("err%0d_rdata", i), last_rdata, 32'h0);
            chk($sformatf("err%0d_lat", i), last_lat, 32'd1);
        end

        rc = rsp_count;
        send(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, s);
        send(1'b1, 3'b010, 32'h14, 32'h5, 1'b0, s);
        chk("b2b_overlap", {31'h0, s}, 32'h1);
        drain();
        chk("b2b_count", rsp_count - rc, 32'd2);
        chk("b2b_mem", tb_mem[5], 32'h5);

        send(1'b1, 3'b000, 32'h08, 32'h000000CD, 1'b0, s);
        #2 reset = 1'b1;
        #1;
        chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_mem_we", {31'h0, mem_WE}, 32'h0);
        chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("abort_mem_a", mem_A, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rc = rsp_count;
        repeat (4) @(negedge clk);
        chk("abort_no_rsp", rsp_count - rc, 32'd0);
        chk("abort_mem", tb_mem[2], 32'hA5000002);
        chk("abort_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 64; i++) begin
            total++;
            if (tb_mem[i] !== ref_mem[i]) begin
                bad++;
                $display("FAIL mem_final[%0d]: got %h want %h", i, tb_mem[i], ref_mem[i]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
